// File: rtl/crop_pixel_packer.sv
// Converts the cropped rgb888 stream to RGB565, packs PPW pixels per word and
// buffers the words in a small FIFO behind a valid/ready master port.
module crop_pixel_packer #(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs_i,
  input  logic              de_i,
  input  logic [23:0]       rgb_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              synced
);

  localparam int PPW = DATA_W / 16;
  localparam int PW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;

  // valid/ready: a word transfers on every cycle where m_valid & m_ready are
  // both high; while m_valid is high and m_ready low, m_data/m_sof are held.

  logic              vs_d;
  logic              sof_pend;
  logic [PW-1:0]     pix_cnt;
  logic [DATA_W-1:0] asm_word;
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     mem_cnt;

  logic              vs_rise;
  logic              take;
  logic              last_lane;
  logic [15:0]       p565;
  logic [DATA_W-1:0] asm_next;
  logic [DATA_W-1:0] push_word;
  logic              push;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic              load;
  logic [CW-1:0]     total;

  always_comb begin
    vs_rise   = vs_i & ~vs_d;
    take      = de_i & ~vs_i & synced;
    last_lane = (pix_cnt == PW'(PPW - 1));
    p565      = {rgb_i[23:19], rgb_i[15:10], rgb_i[7:3]};
    asm_next  = asm_word | (DATA_W'(p565) << {pix_cnt, 4'b0000});
    // Flush (on vs rise) and full-word push are exclusive since vs_i blocks pixels.
    push      = (vs_rise & (pix_cnt != '0)) | (take & last_lane);
    push_word = vs_rise ? asm_word : asm_next;
    pop       = m_valid & m_ready;
    // Occupancy counts the output register as one of the FIFO_DEPTH entries.
    total     = mem_cnt + CW'(m_valid);
    full      = (total == CW'(FIFO_DEPTH));
    push_ok   = push & (~full | pop);
    load      = (mem_cnt != '0) & (~m_valid | m_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d     <= 1'b0;
      synced   <= 1'b0;
      sof_pend <= 1'b0;
      pix_cnt  <= '0;
      asm_word <= '0;
      drop_cnt <= '0;
    end else begin
      vs_d <= vs_i;
      if (vs_rise) begin
        synced   <= 1'b1;
        pix_cnt  <= '0;
        asm_word <= '0;
      end else if (take) begin
        if (last_lane) begin
          pix_cnt  <= '0;
          asm_word <= '0;
        end else begin
          pix_cnt  <= pix_cnt + PW'(1);
          asm_word <= asm_next;
        end
      end
      if (vs_rise) sof_pend <= 1'b1;
      else if (push_ok) sof_pend <= 1'b0;
      if (push & ~push_ok & (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {sof_pend, push_word};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      mem_cnt <= mem_cnt + CW'(push_ok) - CW'(load);
      if (load) begin
        m_valid         <= 1'b1;
        {m_sof, m_data} <= mem[rd_ptr];
        rd_ptr          <= rd_ptr + AW'(1);
      end else if (pop) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crop_pixel_packer.sv
// Bench for crop_pixel_packer: directed frame scenarios plus a random phase,
// checked against a word-level queue model of packing, flushing and dropping.
module tb_crop_pixel_packer;

  localparam int DATA_W     = 128;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;
  localparam int PPW        = DATA_W / 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              vs_i = 1'b0;
  logic              de_i = 1'b0;
  logic [23:0]       rgb_i = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_sof;
  logic [CNT_W-1:0]  drop_cnt;
  logic              synced;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DATA_W:0]  exp_q[$];
  logic [15:0]      pix_q[$];
  logic             md_synced;
  logic             md_vsd;
  logic             md_sof_pend;
  logic [CNT_W-1:0] md_drop;

  crop_pixel_packer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .vs_i(vs_i), .de_i(de_i), .rgb_i(rgb_i),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
    .drop_cnt(drop_cnt), .synced(synced)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to565(input logic [23:0] rgb);
    int r, g, b;
    r = int'(rgb[23:16]) / 8;
    g = int'(rgb[15:8]) / 4;
    b = int'(rgb[7:0]) / 8;
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  function automatic logic [DATA_W-1:0] pack_pixels();
    logic [DATA_W-1:0] w;
    w = '0;
    foreach (pix_q[i]) w[16*i +: 16] = pix_q[i];
    return w;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    pix_q.delete();
    md_synced   = 1'b0;
    md_vsd      = 1'b0;
    md_sof_pend = 1'b0;
    md_drop     = '0;
  endtask

  // One clock: check outputs and advance the model on the falling edge, then
  // pass the rising edge and return just after it.
  task automatic tick();
    logic              pop, push, vs_rise, sof_w;
    logic [DATA_W-1:0] word;
    int                occ;
    @(negedge clk);
    chk("drop_cnt", DATA_W'(drop_cnt), DATA_W'(md_drop));
    chk("synced", DATA_W'(synced), DATA_W'(md_synced));
    if (m_valid) begin
      chk("head_avail", DATA_W'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("head_word", {m_sof, m_data}, exp_q[0]);
    end
    pop  = m_valid && m_ready;
    occ  = exp_q.size();
    if (pop && occ != 0) void'(exp_q.pop_front());
    vs_rise = vs_i && !md_vsd;
    push  = 1'b0;
    word  = '0;
    sof_w = md_sof_pend;
    if (vs_rise) begin
      if (pix_q.size() != 0) begin
        push = 1'b1;
        word = pack_pixels();
        pix_q.delete();
      end
    end else if (de_i && !vs_i && md_synced) begin
      pix_q.push_back(to565(rgb_i));
      if (pix_q.size() == PPW) begin
        push = 1'b1;
        word = pack_pixels();
        pix_q.delete();
      end
    end
    if (push) begin
      if (occ == FIFO_DEPTH && !pop) begin
        if (md_drop != {CNT_W{1'b1}}) md_drop = md_drop + 1'b1;
      end else begin
        exp_q.push_back({sof_w, word});
        md_sof_pend = 1'b0;
      end
    end
    if (vs_rise) begin
      md_synced   = 1'b1;
      md_sof_pend = 1'b1;
    end
    md_vsd = vs_i;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vs_i = 1'b0;
    de_i = 1'b0;
    rst  = 1'b1;
    #1;
    chk("rst_valid", DATA_W'(m_valid), 0);
    chk("rst_data", {1'b0, m_data}, 0);
    chk("rst_sof", DATA_W'(m_sof), 0);
    chk("rst_drop", DATA_W'(drop_cnt), 0);
    chk("rst_synced", DATA_W'(synced), 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic vs_pulse();
    de_i = 1'b0;
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
    tick();
  endtask

  task automatic pixel(input logic [23:0] rgb);
    de_i  = 1'b1;
    rgb_i = rgb;
    tick();
    de_i  = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    de_i    = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", DATA_W'(exp_q.size()), 0);
    tick();
    chk("drain_idle", DATA_W'(m_valid), 0);
  endtask

  initial begin
    logic [DATA_W-1:0] t2_word;
    model_clear();
    #3;
    do_reset();

    // unsynced pixels are ignored
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) pixel(24'hFF_FF_FF);
    tick();
    tick();
    chk("t1_valid", DATA_W'(m_valid), 0);
    chk("t1_synced", DATA_W'(synced), 0);

    // ramp frame: lanes 4..7 convert to 16'h0020
    vs_pulse();
    for (int k = 0; k < 8; k++) pixel({8'(k), 8'(k), 8'(k)});
    t2_word = {16'h0020, 16'h0020, 16'h0020, 16'h0020, 64'h0};
    tick();
    chk("t2_valid", DATA_W'(m_valid), 1);
    chk("t2_word", {m_sof, m_data}, {1'b1, t2_word});
    drain();

    // 20 pixels then flush on the next frame start
    vs_pulse();
    for (int i = 0; i < 20; i++) pixel(24'hF8_FC_F8);
    chk("t3_partial_held", DATA_W'(exp_q.size() == 0 && !m_valid), 1);
    vs_pulse();
    drain();

    // back-pressure: 6 words into 4 entries
    m_ready = 1'b0;
    vs_pulse();
    for (int i = 0; i < 48; i++) pixel(24'($urandom));
    tick();
    chk("t4_drop", DATA_W'(drop_cnt), 2);
    chk("t4_held", DATA_W'(exp_q.size()), 4);
    repeat (3) tick();
    drain();

    // full FIFO with a pop on the completing pixel
    m_ready = 1'b0;
    vs_pulse();
    for (int i = 0; i < 32; i++) pixel(24'($urandom));
    for (int i = 0; i < 7; i++) pixel(24'($urandom));
    m_ready = 1'b1;
    pixel(24'($urandom));
    m_ready = 1'b0;
    tick();
    chk("t5_drop", DATA_W'(drop_cnt), 2);
    chk("t5_held", DATA_W'(exp_q.size()), 4);
    drain();

    // random traffic
    for (int c = 0; c < 700; c++) begin
      vs_i    = ($urandom_range(0, 59) == 0);
      de_i    = ($urandom_range(0, 3) != 0);
      rgb_i   = 24'($urandom);
      m_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    vs_i = 1'b0;
    drain();

    // reset in the middle of a word
    vs_pulse();
    for (int i = 0; i < 5; i++) pixel(24'($urandom));
    #3;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) pixel(24'h12_34_56);
    tick();
    chk("t6_unsynced", DATA_W'(m_valid), 0);
    vs_pulse();
    for (int i = 0; i < 8; i++) pixel({8'(i * 32), 8'(i * 16), 8'(255 - i * 8)});
    tick();
    chk("t6_sof", DATA_W'(m_sof && m_valid), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
